game_fsm: RTL
=============

GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter DODGE_TICKS, default 7: tick pulses spent in DODGE per round.
REQ-002 Parameter MON_HP_MAX, default 100: monster HP loaded at game start (1..2^HP_W-1).
REQ-003 Parameter HP_W, default 8: width of monHP, dmgMon, damage.
REQ-004 Parameter NUM_ACTIONS, default 4: ACTION menu entries (2..16).
REQ-005 Parameter HEAL_AMT, default 10: heal amount placed in a HPY instruction.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  system clock; all state changes on posedge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 tick  in  1  one-clk-wide 1 Hz enable pulse, synchronous to clk.
REQ-010 key  in  4  decoded key: 0 none, 1 W, 2 A, 3 S, 4 D, 5 J, 6 K, 7 L, 8 SPACE.
REQ-011 isDeath  in  1  player HP reached zero.
REQ-012 atkPass  in  1  attack minigame finished, dmgMon valid.
REQ-013 dmgMon  in  HP_W  damage dealt to monster.
REQ-014 isDmgComplete  in  1  player hit by bullet this cycle.
REQ-015 damage  in  HP_W  damage to player.
REQ-016 heal  in  1  hit object is a heal item.
REQ-017 state  out  8  {page[3:0], substate[3:0]}.
REQ-018 playerInstruction  out  16  {opcode[3:0], operand[7:0], 4'b0}.
REQ-019 isMove  out  1  movement instruction valid this cycle.
REQ-020 startDmg  out  1  HPY/DPY instruction valid this cycle.
REQ-021 monHP  out  HP_W  remaining monster HP.
REQ-022 round  out  8  completed DODGE rounds, saturating at 255.

Function
REQ-023 Pages SHALL be MENU=1, WIN=2, LOSE=3, DODGE=9, ATTACK=10, ACTION=11; any other page SHALL go to {MENU,0} next cycle.
REQ-024 All outputs SHALL be registered; isMove and startDmg SHALL be single-cycle pulses, 0 otherwise.
REQ-025 MENU: key==SPACE -> {ACTION,0}, monHP<=MON_HP_MAX, round<=0, tick counter<=0.
REQ-026 ACTION: substate is cursor; A decrements, D increments, wrapping 0<->NUM_ACTIONS-1; J with cursor 0 -> {ATTACK,0}; J with cursor!=0 -> {DODGE,0}.
REQ-027 ATTACK: atkPass==1 -> monHP<=max(monHP-dmgMon,0) (saturating, no wrap); result 0 -> {WIN,0}, else {DODGE,0}.
REQ-028 DODGE: counter increments on tick; entry clears it.
REQ-029 DODGE priority per cycle: isDeath -> {LOSE,0}; else counter==DODGE_TICKS -> {ACTION,0}, round+1; else isDmgComplete -> damage instruction; else movement.
REQ-030 Damage instruction: heal==1 -> {HPY=1,HEAL_AMT,0}, else {DPY=2,damage,0}; startDmg=1 same cycle playerInstruction updates.
REQ-031 Movement: W/A/S/D -> {MOV=5, dir 0/1/2/3, 0}, isMove=1; other keys -> playerInstruction 0, isMove=0.
REQ-032 Outside DODGE, playerInstruction SHALL be 0.
REQ-033 WIN/LOSE: key==SPACE -> {MENU,0}; monHP and round hold.
REQ-034 tick coinciding with isDeath SHALL not increment round.

Reset
REQ-035 rst_n low SHALL immediately force state={MENU,0}, playerInstruction=0, isMove=0, startDmg=0, monHP=0, round=0, tick counter=0.
REQ-036 Reset mid-DODGE or mid-ATTACK SHALL discard pending damage/attack with no output pulse.

Configuration
REQ-037 Macro GAME_FSM_HEAL_EN defined: heal input honoured per REQ-030.
REQ-038 Macro GAME_FSM_HEAL_EN undefined: heal ignored, every hit issues DPY; HPY never emitted.

Verification
REQ-039 Reset, SPACE, D,D,D,D, J -> cursor 1,2,3,0; J enters {ATTACK,0} (0xA0).
REQ-040 ATTACK monHP=100, atkPass dmgMon=60 twice -> monHP 40 then 0, state 0x20 (WIN).
REQ-041 DODGE, 7 ticks, no hits -> state 0xB0 after 7th tick, round=1.
REQ-042 DODGE, isDmgComplete damage=3 heal=0 -> playerInstruction 0x2030, startDmg 1 cycle; heal=1 -> 0x10A0 (HEAL_EN) or 0x2030 (not).
REQ-043 DODGE, isDeath and 7th tick same cycle -> state 0x30, round unchanged.
REQ-044 DODGE, key W held; rst_n low mid-cycle -> state 0x10, isMove 0 asynchronously.

Source files
------------

// File: rtl/game_fsm.sv
// game_fsm: top-level page/substate controller for the battle game.
//   Pages: MENU -> ACTION (cursor menu) -> ATTACK or DODGE -> ACTION ... -> WIN/LOSE.
//   In DODGE the block issues movement or damage/heal instructions to the player unit.
//   Every output is driven straight from a register.
// Configuration macro: GAME_FSM_HEAL_EN
//   defined   - the heal input turns a hit into a HPY (heal) instruction
//   undefined - heal is ignored and every hit issues a DPY (damage) instruction
module game_fsm #(
    parameter int DODGE_TICKS = 7,
    parameter int MON_HP_MAX  = 100,
    parameter int HP_W        = 8,
    parameter int NUM_ACTIONS = 4,
    parameter int HEAL_AMT    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [3:0]      key,
    input  logic            isDeath,
    input  logic            atkPass,
    input  logic [HP_W-1:0] dmgMon,
    input  logic            isDmgComplete,
    input  logic [HP_W-1:0] damage,
    input  logic            heal,
    output logic [7:0]      state,
    output logic [15:0]     playerInstruction,
    output logic            isMove,
    output logic            startDmg,
    output logic [HP_W-1:0] monHP,
    output logic [7:0]      round
);

    typedef enum logic [3:0] {
        PG_MENU   = 4'd1,
        PG_WIN    = 4'd2,
        PG_LOSE   = 4'd3,
        PG_DODGE  = 4'd9,
        PG_ATTACK = 4'd10,
        PG_ACTION = 4'd11
    } page_t;

    localparam logic [3:0] KEY_W     = 4'd1;
    localparam logic [3:0] KEY_A     = 4'd2;
    localparam logic [3:0] KEY_S     = 4'd3;
    localparam logic [3:0] KEY_D     = 4'd4;
    localparam logic [3:0] KEY_J     = 4'd5;
    localparam logic [3:0] KEY_SPACE = 4'd8;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_MOV = 4'd5;

    localparam logic [3:0]      CUR_LAST  = 4'(NUM_ACTIONS - 1);
    localparam logic [7:0]      DODGE_END = 8'(DODGE_TICKS);
    localparam logic [HP_W-1:0] HP_START  = HP_W'(MON_HP_MAX);
    localparam logic [7:0]      HEAL_OPND = 8'(HEAL_AMT);

    // Pack an instruction word: opcode, 8-bit operand, low nibble always zero.
    function automatic logic [15:0] make_instr(input logic [3:0] op, input logic [7:0] opnd);
        return {op, opnd, 4'b0000};
    endfunction

    // Monster HP after a hit, clamped at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? (hp - dmg) : {HP_W{1'b0}};
    endfunction

    page_t           page_r, page_nx_s;
    logic [3:0]      sub_r, sub_nx_s;
    logic [15:0]     instr_r, instr_nx_s;
    logic            move_r, move_nx_s;
    logic            dmg_r, dmg_nx_s;
    logic [HP_W-1:0] hp_r, hp_nx_s;
    logic [7:0]      round_r, round_nx_s;
    logic [7:0]      cnt_r, cnt_nx_s;

    logic [7:0]      cnt_inc_s;
    logic [HP_W-1:0] hp_left_s;
    logic [3:0]      cur_dec_s;
    logic [3:0]      cur_inc_s;
    logic [7:0]      round_inc_s;
    logic            heal_en_s;

`ifdef GAME_FSM_HEAL_EN
    assign heal_en_s = heal;
`else
    logic unused_heal_s;
    assign unused_heal_s = heal;
    assign heal_en_s     = 1'b0;
`endif

    // The tick arriving this cycle counts toward the round, so the round can end on the tick itself.
    assign cnt_inc_s   = cnt_r + {7'd0, tick};
    assign hp_left_s   = sat_sub(hp_r, dmgMon);
    assign cur_dec_s   = (sub_r == 4'd0) ? CUR_LAST : (sub_r - 4'd1);
    assign cur_inc_s   = (sub_r == CUR_LAST) ? 4'd0 : (sub_r + 4'd1);
    assign round_inc_s = (round_r == 8'd255) ? round_r : (round_r + 8'd1);

    // Next-state and next-output decode for every page.
    always_comb begin
        page_nx_s  = page_r;
        sub_nx_s   = sub_r;
        hp_nx_s    = hp_r;
        round_nx_s = round_r;
        cnt_nx_s   = cnt_r;
        instr_nx_s = 16'h0000;
        move_nx_s  = 1'b0;
        dmg_nx_s   = 1'b0;
        case (page_r)
            PG_MENU: begin
                if (key == KEY_SPACE) begin
                    page_nx_s  = PG_ACTION;
                    sub_nx_s   = 4'd0;
                    hp_nx_s    = HP_START;
                    round_nx_s = 8'd0;
                    cnt_nx_s   = 8'd0;
                end else begin
                    page_nx_s = PG_MENU;
                end
            end
            PG_ACTION: begin
                if (key == KEY_A) begin
                    sub_nx_s = cur_dec_s;
                end else if (key == KEY_D) begin
                    sub_nx_s = cur_inc_s;
                end else if (key == KEY_J) begin
                    page_nx_s = (sub_r == 4'd0) ? PG_ATTACK : PG_DODGE;
                    sub_nx_s  = 4'd0;
                    cnt_nx_s  = 8'd0;
                end else begin
                    sub_nx_s = sub_r;
                end
            end
            PG_ATTACK: begin
                if (atkPass) begin
                    hp_nx_s  = hp_left_s;
                    sub_nx_s = 4'd0;
                    cnt_nx_s = 8'd0;
                    if (hp_left_s == {HP_W{1'b0}}) begin
                        page_nx_s = PG_WIN;
                    end else begin
                        page_nx_s = PG_DODGE;
                    end
                end else begin
                    hp_nx_s = hp_r;
                end
            end
            PG_DODGE: begin
                if (isDeath) begin
                    page_nx_s = PG_LOSE;
                    sub_nx_s  = 4'd0;
                end else if (cnt_inc_s == DODGE_END) begin
                    page_nx_s  = PG_ACTION;
                    sub_nx_s   = 4'd0;
                    round_nx_s = round_inc_s;
                    cnt_nx_s   = 8'd0;
                end else begin
                    cnt_nx_s = cnt_inc_s;
                    if (isDmgComplete) begin
                        dmg_nx_s = 1'b1;
                        if (heal_en_s) begin
                            instr_nx_s = make_instr(OP_HPY, HEAL_OPND);
                        end else begin
                            instr_nx_s = make_instr(OP_DPY, 8'(damage));
                        end
                    end else begin
                        case (key)
                            KEY_W: begin
                                move_nx_s  = 1'b1;
                                instr_nx_s = make_instr(OP_MOV, 8'd0);
                            end
                            KEY_A: begin
                                move_nx_s  = 1'b1;
                                instr_nx_s = make_instr(OP_MOV, 8'd1);
                            end
                            KEY_S: begin
                                move_nx_s  = 1'b1;
                                instr_nx_s = make_instr(OP_MOV, 8'd2);
                            end
                            KEY_D: begin
                                move_nx_s  = 1'b1;
                                instr_nx_s = make_instr(OP_MOV, 8'd3);
                            end
                            default: begin
                                move_nx_s  = 1'b0;
                                instr_nx_s = 16'h0000;
                            end
                        endcase
                    end
                end
            end
            PG_WIN, PG_LOSE: begin
                if (key == KEY_SPACE) begin
                    page_nx_s = PG_MENU;
                    sub_nx_s  = 4'd0;
                end else begin
                    page_nx_s = page_r;
                end
            end
            default: begin
                page_nx_s = PG_MENU;
                sub_nx_s  = 4'd0;
            end
        endcase
    end

    // State and output registers; reset drops any pending instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_r  <= PG_MENU;
            sub_r   <= 4'd0;
            instr_r <= 16'h0000;
            move_r  <= 1'b0;
            dmg_r   <= 1'b0;
            hp_r    <= {HP_W{1'b0}};
            round_r <= 8'd0;
            cnt_r   <= 8'd0;
        end else begin
            page_r  <= page_nx_s;
            sub_r   <= sub_nx_s;
            instr_r <= instr_nx_s;
            move_r  <= move_nx_s;
            dmg_r   <= dmg_nx_s;
            hp_r    <= hp_nx_s;
            round_r <= round_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign state             = {page_r, sub_r};
    assign playerInstruction = instr_r;
    assign isMove            = move_r;
    assign startDmg          = dmg_r;
    assign monHP             = hp_r;
    assign round             = round_r;

endmodule
